// File: rtl/intel_emif_reconfig_reset_seq.sv
// rtl/intel_emif_reconfig_reset_seq.sv - EMIF user-reset sequencer for clock-generator reconfiguration
// Holds the EMIF in reset across reconfig plus settle time, then supervises calibration with bounded retries.
module intel_emif_reconfig_reset_seq #(
    parameter logic USER_RESET_ACTIVE_HIGH = 1'b0,
    parameter int   SETTLE_CYCLES          = 1024,
    parameter int   CAL_TIMEOUT_CYCLES     = 1048576,
    parameter int   MAX_RETRIES            = 3,
    parameter int   SYNC_STAGES            = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reconfig_busy,
    input  logic       cal_success,
    input  logic       cal_fail,
    input  logic       retry_req,
    output logic       user_reset,
    output logic       emif_ready,
    output logic       seq_error,
    output logic [3:0] retry_count
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(CAL_TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic          RST_ON       = USER_RESET_ACTIVE_HIGH;
    localparam logic          RST_OFF      = ~USER_RESET_ACTIVE_HIGH;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_BUSY,
        ST_CAL_WAIT,
        ST_READY,
        ST_ERROR
    } state_t;

    logic [SYNC_STAGES-1:0] busy_sync;
    logic [SYNC_STAGES-1:0] success_sync;
    logic [SYNC_STAGES-1:0] fail_sync;
    logic                   busy_s;
    logic                   success_s;
    logic                   fail_s;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_cnt_nx;
    logic [TW-1:0] cal_tmr;
    logic [TW-1:0] cal_tmr_nx;
    logic [3:0]    retry_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_sync    <= '0;
            success_sync <= '0;
            fail_sync    <= '0;
        end else begin
            busy_sync    <= {busy_sync[SYNC_STAGES-2:0], reconfig_busy};
            success_sync <= {success_sync[SYNC_STAGES-2:0], cal_success};
            fail_sync    <= {fail_sync[SYNC_STAGES-2:0], cal_fail};
        end
    end

    assign busy_s    = busy_sync[SYNC_STAGES-1];
    assign success_s = success_sync[SYNC_STAGES-1];
    assign fail_s    = fail_sync[SYNC_STAGES-1];

    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        cal_tmr_nx    = cal_tmr;
        retry_nx      = retry_count;
        if (busy_s) begin
            state_nx      = ST_BUSY;
            settle_cnt_nx = '0;
            cal_tmr_nx    = '0;
            retry_nx      = '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    state_nx      = ST_SETTLE;
                    settle_cnt_nx = '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nx   = ST_CAL_WAIT;
                        cal_tmr_nx = '0;
                    end else begin
                        settle_cnt_nx = settle_cnt + 1'b1;
                    end
                end
                ST_CAL_WAIT: begin
                    // Failure is evaluated first so a simultaneous fail+success counts as a fail.
                    if (fail_s || (cal_tmr == TIMEOUT_LAST)) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_nx      = retry_count + 4'd1;
                            state_nx      = ST_SETTLE;
                            settle_cnt_nx = '0;
                        end else begin
                            state_nx = ST_ERROR;
                        end
                    end else begin
                        cal_tmr_nx = cal_tmr + 1'b1;
                        if (success_s) begin
                            state_nx = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    state_nx = ST_READY;
                end
                ST_ERROR: begin
                    if (retry_req) begin
                        state_nx      = ST_SETTLE;
                        settle_cnt_nx = '0;
                        retry_nx      = '0;
                    end
                end
                default: begin
                    state_nx      = ST_SETTLE;
                    settle_cnt_nx = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            cal_tmr     <= '0;
            retry_count <= '0;
            user_reset  <= RST_ON;
            emif_ready  <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_nx;
            settle_cnt  <= settle_cnt_nx;
            cal_tmr     <= cal_tmr_nx;
            retry_count <= retry_nx;
            user_reset  <= ((state_nx == ST_CAL_WAIT) || (state_nx == ST_READY)) ? RST_OFF : RST_ON;
            emif_ready  <= (state_nx == ST_READY);
            seq_error   <= (state_nx == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_intel_emif_reconfig_reset_seq.sv
// tb/tb_intel_emif_reconfig_reset_seq.sv - bench for intel_emif_reconfig_reset_seq
// Timestamp-based phase model checked every cycle, plus directed literal checks and random stimulus.
module tb_intel_emif_reconfig_reset_seq;

    localparam int   SETTLE = 16;
    localparam int   TMO    = 64;
    localparam int   MAXR   = 2;
    localparam int   SYNC   = 2;
    localparam logic UR_ACT = 1'b0;

    localparam int PH_SETTLE = 0;
    localparam int PH_BUSY   = 1;
    localparam int PH_CAL    = 2;
    localparam int PH_READY  = 3;
    localparam int PH_ERROR  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reconfig_busy;
    logic       cal_success;
    logic       cal_fail;
    logic       retry_req;
    logic       user_reset;
    logic       emif_ready;
    logic       seq_error;
    logic [3:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;

    intel_emif_reconfig_reset_seq #(
        .USER_RESET_ACTIVE_HIGH(UR_ACT),
        .SETTLE_CYCLES(SETTLE),
        .CAL_TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(MAXR),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reconfig_busy(reconfig_busy),
        .cal_success(cal_success),
        .cal_fail(cal_fail),
        .retry_req(retry_req),
        .user_reset(user_reset),
        .emif_ready(emif_ready),
        .seq_error(seq_error),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // Model: phase plus the edge number at which it was entered; async inputs delayed by a queue.
    int m_n = 0;
    int m_start = 0;
    int m_ph = PH_SETTLE;
    int m_retries = 0;
    bit m_valid = 0;
    bit qb[$];
    bit qs[$];
    bit qf[$];

    task automatic enter(input int ph);
        m_ph    = ph;
        m_start = m_n;
    endtask

    task automatic model_step();
        bit bs, ss, fs;
        int age;
        m_n++;
        if (!rst_n) begin
            enter(PH_SETTLE);
            m_retries = 0;
            qb.delete(); qs.delete(); qf.delete();
            for (int i = 0; i < SYNC; i++) begin
                qb.push_back(1'b0); qs.push_back(1'b0); qf.push_back(1'b0);
            end
            m_valid = 1;
            return;
        end
        if (!m_valid) return;
        bs = qb.pop_front(); ss = qs.pop_front(); fs = qf.pop_front();
        qb.push_back(reconfig_busy); qs.push_back(cal_success); qf.push_back(cal_fail);
        age = m_n - m_start;
        if (bs) begin
            enter(PH_BUSY);
            m_retries = 0;
        end else if (m_ph == PH_BUSY) begin
            enter(PH_SETTLE);
        end else if (m_ph == PH_SETTLE) begin
            if (age == SETTLE) enter(PH_CAL);
        end else if (m_ph == PH_CAL) begin
            if (fs || age == TMO) begin
                if (m_retries < MAXR) begin
                    m_retries++;
                    enter(PH_SETTLE);
                end else begin
                    enter(PH_ERROR);
                end
            end else if (ss) begin
                enter(PH_READY);
            end
        end else if (m_ph == PH_ERROR) begin
            if (retry_req) begin
                m_retries = 0;
                enter(PH_SETTLE);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            logic exp_ur;
            exp_ur = (m_ph == PH_CAL || m_ph == PH_READY) ? ~UR_ACT : UR_ACT;
            n_tests++;
            if (user_reset !== exp_ur || emif_ready !== (m_ph == PH_READY) ||
                seq_error !== (m_ph == PH_ERROR) || retry_count !== 4'(m_retries)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got ur=%b rdy=%b err=%b rc=%0d expected ur=%b rdy=%b err=%b rc=%0d",
                         $time, user_reset, emif_ready, seq_error, retry_count,
                         exp_ur, (m_ph == PH_READY), (m_ph == PH_ERROR), m_retries);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return user_reset;
            1:       return emif_ready;
            default: return seq_error;
        endcase
    endfunction

    // Counts negedges until the chosen output equals val (bounded).
    task automatic wait_sig(input int w, input logic val, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sig(w) !== val && k < 300);
    endtask

    // Length of the run of user_reset==val starting at the current negedge.
    task automatic run_len(input logic val, output int len);
        len = 0;
        while (user_reset === val && len < 500) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    int k;
    int len;
    int busy_left;

    initial begin
        rst_n = 0; reconfig_busy = 0; cal_success = 0; cal_fail = 0; retry_req = 0;
        repeat (3) @(negedge clk);
        check("reset_user_reset", user_reset, 0);
        check("reset_emif_ready", emif_ready, 0);
        check("reset_seq_error", seq_error, 0);
        check("reset_retry_count", retry_count, 0);

        rst_n = 1;
        wait_sig(0, 1'b1, k);
        check("powerup_settle_len", k, 16);
        repeat (4) @(negedge clk);
        cal_success = 1;
        wait_sig(1, 1'b1, k);
        check("powerup_ready_latency", k, 3);

        reconfig_busy = 1; cal_success = 0;
        wait_sig(0, 1'b0, k);
        check("reconfig_assert_latency", k, 3);
        check("reconfig_ready_drop", emif_ready, 0);
        repeat (7) @(negedge clk);
        reconfig_busy = 0;
        run_len(1'b0, len);
        check("reconfig_low_after_fall", len, 19);

        run_len(1'b1, len);
        check("timeout_window_0", len, 64);
        check("retry_count_1", retry_count, 1);
        run_len(1'b0, len);
        check("retry_settle_1", len, 16);
        run_len(1'b1, len);
        check("timeout_window_1", len, 64);
        check("retry_count_2", retry_count, 2);
        run_len(1'b0, len);
        check("retry_settle_2", len, 16);
        run_len(1'b1, len);
        check("timeout_window_2", len, 64);
        check("error_seq_error", seq_error, 1);
        check("error_user_reset", user_reset, 0);
        repeat (5) @(negedge clk);
        check("error_held", {seq_error, user_reset}, 2);

        retry_req = 1;
        @(negedge clk);
        retry_req = 0;
        check("recovery_seq_error", seq_error, 0);
        check("recovery_user_reset", user_reset, 0);
        check("recovery_retry_count", retry_count, 0);
        run_len(1'b0, len);
        check("recovery_settle", len, 16);
        cal_success = 1;
        wait_sig(1, 1'b1, k);
        check("recovery_ready_latency", k, 3);
        check("recovery_no_error", seq_error, 0);

        cal_success = 0; reconfig_busy = 1;
        repeat (3) @(negedge clk);
        reconfig_busy = 0;
        wait_sig(0, 1'b1, k);
        check("simul_reach_cal", k, 19);
        cal_fail = 1; cal_success = 1;
        wait_sig(0, 1'b0, k);
        check("simul_fail_latency", k, 3);
        check("simul_retry_count", retry_count, 1);
        check("simul_not_ready", emif_ready, 0);
        cal_fail = 0; cal_success = 0;

        repeat (5) @(negedge clk);
        reconfig_busy = 1;
        repeat (3) @(negedge clk);
        check("midsettle_retry_clear", retry_count, 0);
        repeat (2) @(negedge clk);
        reconfig_busy = 0;
        run_len(1'b0, len);
        check("midsettle_full_settle", len, 19);

        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midcal_rst_user_reset", user_reset, 0);
        check("midcal_rst_ready_err", {emif_ready, seq_error}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        busy_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            retry_req = ($urandom_range(0, 39) == 0);
            if (busy_left == 0 && $urandom_range(0, 299) == 0) busy_left = $urandom_range(1, 20);
            reconfig_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if ($urandom_range(0, 29) == 0) cal_success = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) cal_fail = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1999) == 0) begin
                #2 rst_n = 0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1;
            end
        end
        retry_req = 0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
